rd_bram_row_ctrl: RTL and testbench

Upstream sequencer for the top-row BRAM reader. It walks feature maps 0..num_of_fm-1 for one (x,y) patch position. For each map it computes the top-row BRAM offset, issues a one-cycle rd_data_bottom request, holds the offset stable, and waits for the reader's rd_data_bram_row_last before moving to the next map. It throttles on proc_ready from the processing registers and flags a watchdog timeout if the reader never answers.

---
 rtl/rd_bram_row_ctrl.sv | 144 ++++++++++++++
 tb/tb_rd_bram_row_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rd_bram_row_ctrl.sv
// Sequencer for the top-row BRAM reader: walks every feature map of one (x,y)
// patch, issuing one read request per map and waiting for the reader's last pulse.
module rd_bram_row_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int FM_W    = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        rd_data_x,
    input  logic [4:0]        rd_data_y,
    input  logic [5:0]        num_of_patch_in_one_bar,
    input  logic [FM_W-1:0]   num_of_fm,
    input  logic [ADDR_W-1:0] fm_stride,
    input  logic              proc_ready,
    input  logic              rd_data_bram_row_last,
    output logic              rd_data_bottom,
    output logic [ADDR_W-1:0] rd_data_bram_row_ith_offset,
    output logic [FM_W-1:0]   ith_fm,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [4:0]        x_q, x_d, y_q, y_d;
    logic [5:0]        np_q, np_d;
    logic [FM_W-1:0]   num_fm_q, num_fm_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] base_xy_q, base_xy_d;
    logic [ADDR_W-1:0] fm_base_q, fm_base_d;
    logic [FM_W-1:0]   ith_fm_q, ith_fm_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic [10:0]       mac;

    // 5x6 multiply plus 5-bit add peaks at 1984, so 11 bits never overflow.
    assign mac = 11'(x_q) * 11'(np_q) + 11'(y_q);

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        np_d           = np_q;
        num_fm_d       = num_fm_q;
        stride_d       = stride_q;
        base_xy_d      = base_xy_q;
        fm_base_d      = fm_base_q;
        ith_fm_d       = ith_fm_q;
        wd_d           = wd_q;
        err_d          = err_q;
        rd_data_bottom = 1'b0;
        done           = 1'b0;
        // NOTE: every variable gets a default above so no path through the case infers a latch.
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d      = rd_data_x;
                    y_d      = rd_data_y;
                    np_d     = num_of_patch_in_one_bar;
                    num_fm_d = num_of_fm;
                    stride_d = fm_stride;
                    err_d    = 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                base_xy_d = ADDR_W'(mac);
                fm_base_d = '0;
                ith_fm_d  = '0;
                state_d   = (num_fm_q == '0) ? S_FIN : S_ISSUE;
            end
            S_ISSUE: begin
                if (proc_ready) begin
                    rd_data_bottom = 1'b1;
                    wd_d           = '0;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                // A last pulse in the expiry cycle still counts as an answer.
                if (rd_data_bram_row_last) begin
                    if (ith_fm_q == num_fm_q - 1'b1) begin
                        state_d = S_FIN;
                    end else begin
                        ith_fm_d  = ith_fm_q + 1'b1;
                        fm_base_d = fm_base_q + stride_q;
                        state_d   = S_ISSUE;
                    end
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            np_q      <= '0;
            num_fm_q  <= '0;
            stride_q  <= '0;
            base_xy_q <= '0;
            fm_base_q <= '0;
            ith_fm_q  <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            np_q      <= np_d;
            num_fm_q  <= num_fm_d;
            stride_q  <= stride_d;
            base_xy_q <= base_xy_d;
            fm_base_q <= fm_base_d;
            ith_fm_q  <= ith_fm_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
        end
    end

    // fm_base only moves on the WAIT->ISSUE step, so the offset stays stable through last.
    assign rd_data_bram_row_ith_offset = fm_base_q + base_xy_q;
    assign ith_fm                      = ith_fm_q;
    assign busy                        = (state_q != S_IDLE);
    assign err_timeout                 = err_q;

endmodule

// File: tb/tb_rd_bram_row_ctrl.sv
// Directed self-checking bench for rd_bram_row_ctrl with a 2-cycle model reader.
module tb_rd_bram_row_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rd_data_x, rd_data_y;
    logic [5:0]  num_of_patch_in_one_bar;
    logic [9:0]  num_of_fm;
    logic [12:0] fm_stride;
    logic        proc_ready;
    logic        rd_data_bram_row_last;
    logic        rd_data_bottom;
    logic [12:0] rd_data_bram_row_ith_offset;
    logic [9:0]  ith_fm;
    logic        busy, done, err_timeout;

    logic        reader_en;
    logic        force_last;
    logic [1:0]  pipe;

    int n_checks = 0;
    int n_fail   = 0;

    rd_bram_row_ctrl dut (
        .clk                         (clk),
        .rst                         (rst),
        .start                       (start),
        .rd_data_x                   (rd_data_x),
        .rd_data_y                   (rd_data_y),
        .num_of_patch_in_one_bar     (num_of_patch_in_one_bar),
        .num_of_fm                   (num_of_fm),
        .fm_stride                   (fm_stride),
        .proc_ready                  (proc_ready),
        .rd_data_bram_row_last       (rd_data_bram_row_last),
        .rd_data_bottom              (rd_data_bottom),
        .rd_data_bram_row_ith_offset (rd_data_bram_row_ith_offset),
        .ith_fm                      (ith_fm),
        .busy                        (busy),
        .done                        (done),
        .err_timeout                 (err_timeout)
    );

    always #5 clk = ~clk;

    // Model reader: last arrives two cycles after each accepted request.
    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= 2'b00;
        else     pipe <= {pipe[0], rd_data_bottom & reader_en};
    end
    assign rd_data_bram_row_last = pipe[1] | force_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int x, input int y, input int np, input int fm, input int stride);
        rd_data_x               = 5'(x);
        rd_data_y               = 5'(y);
        num_of_patch_in_one_bar = 6'(np);
        num_of_fm               = 10'(fm);
        fm_stride               = 13'(stride);
    endtask

    // Three-map run; th = cycles proc_ready is held low from the 2nd request slot.
    task automatic run_three(input string nm, input int stride, input int o0, input int o1,
                             input int o2, input int th);
        int r1, r2, dn, eo, ei;
        r1 = 5 + th;
        r2 = 8 + th;
        dn = 11 + th;
        setup(3, 2, 7, 3, stride);
        for (int c = 0; c <= dn + 1; c++) begin
            start = (c == 0);
            if (c == 1) setup(31, 31, 63, 1, 1);
            if (th > 0 && c == 5) proc_ready = 1'b0;
            if (c == 5 + th) proc_ready = 1'b1;
            #1;
            check($sformatf("%s req c%0d", nm, c), 32'(rd_data_bottom),
                  32'(c == 2 || c == r1 || c == r2));
            check($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'(c >= 1 && c <= dn));
            check($sformatf("%s done c%0d", nm, c), 32'(done), 32'(c == dn));
            if (c >= 2 && c <= dn) begin
                eo = (c < 5) ? o0 : (c < r2) ? o1 : o2;
                ei = (c < 5) ? 0 : (c < r2) ? 1 : 2;
                check($sformatf("%s off c%0d", nm, c), 32'(rd_data_bram_row_ith_offset), 32'(eo));
                check($sformatf("%s ith c%0d", nm, c), 32'(ith_fm), 32'(ei));
            end
            tick();
        end
        check({nm, " err"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        proc_ready = 1'b1;
        reader_en  = 1'b1;
        force_last = 1'b0;
        setup(0, 0, 0, 0, 0);
        #12;
        check("rst req",  32'(rd_data_bottom), 32'd0);
        check("rst off",  32'(rd_data_bram_row_ith_offset), 32'd0);
        check("rst ith",  32'(ith_fm), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err",  32'(err_timeout), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_three("basic",    100,  23,  123, 223, 0);
        run_three("wrap",     4096, 23, 4119,  23, 0);
        run_three("throttle", 100,  23,  123, 223, 4);

        // Zero maps: straight from CALC to FIN.
        setup(3, 2, 7, 0, 100);
        for (int c = 0; c <= 3; c++) begin
            start = (c == 0);
            #1;
            check($sformatf("zero req c%0d", c),  32'(rd_data_bottom), 32'd0);
            check($sformatf("zero done c%0d", c), 32'(done), 32'(c == 2));
            check($sformatf("zero busy c%0d", c), 32'(busy), 32'(c == 1 || c == 2));
            check($sformatf("zero err c%0d", c),  32'(err_timeout), 32'd0);
            tick();
        end

        // Timeout: reader silent, 15 cycles in WAIT (c3..c17), FIN at c18.
        reader_en = 1'b0;
        setup(3, 2, 7, 3, 100);
        for (int c = 0; c <= 19; c++) begin
            start = (c == 0);
            #1;
            check($sformatf("tmo req c%0d", c),  32'(rd_data_bottom), 32'(c == 2));
            check($sformatf("tmo done c%0d", c), 32'(done), 32'(c == 18));
            check($sformatf("tmo busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 18));
            check($sformatf("tmo err c%0d", c),  32'(err_timeout), 32'(c >= 18));
            tick();
        end

        // Stray last while idle changes nothing.
        force_last = 1'b1;
        #1;
        check("stray busy", 32'(busy), 32'd0);
        tick();
        force_last = 1'b0;
        #1;
        check("stray busy2", 32'(busy), 32'd0);
        check("stray err",   32'(err_timeout), 32'd1);
        check("stray done",  32'(done), 32'd0);
        tick();

        // Last in the expiry cycle (wd=TIMEOUT-1 at c17) wins; start clears the sticky error.
        setup(3, 2, 7, 1, 100);
        for (int c = 0; c <= 19; c++) begin
            start      = (c == 0);
            force_last = (c == 17);
            #1;
            if (c >= 1) check($sformatf("lw err c%0d", c), 32'(err_timeout), 32'd0);
            check($sformatf("lw done c%0d", c), 32'(done), 32'(c == 18));
            check($sformatf("lw busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 18));
            tick();
        end
        force_last = 1'b0;
        reader_en  = 1'b1;

        // Reset mid-WAIT on map 1, with a start pulse while busy at c3.
        setup(3, 2, 7, 3, 100);
        for (int c = 0; c <= 6; c++) begin
            start = (c == 0 || c == 3);
            #1;
            check($sformatf("mid req c%0d", c), 32'(rd_data_bottom), 32'(c == 2 || c == 5));
            if (c >= 5) begin
                check($sformatf("mid off c%0d", c), 32'(rd_data_bram_row_ith_offset), 32'd123);
                check($sformatf("mid ith c%0d", c), 32'(ith_fm), 32'd1);
            end
            if (c < 6) tick();
        end
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check("arst req",  32'(rd_data_bottom), 32'd0);
        check("arst off",  32'(rd_data_bram_row_ith_offset), 32'd0);
        check("arst ith",  32'(ith_fm), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst err",  32'(err_timeout), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("hold done %0d", c), 32'(done), 32'd0);
            check($sformatf("hold busy %0d", c), 32'(busy), 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("post busy %0d", c), 32'(busy), 32'd0);
            check($sformatf("post req %0d", c),  32'(rd_data_bottom), 32'd0);
            check($sformatf("post done %0d", c), 32'(done), 32'd0);
            check($sformatf("post ith %0d", c),  32'(ith_fm), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
